// File: rtl/spu_result_decode.sv
// rtl/spu_result_decode.sv - SPU result record capture FIFO with error decode and statistics
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 2
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif
`ifndef SNT_PKT_RSP_TYPE
`define SNT_PKT_RSP_TYPE 2'd1
`endif

module spu_result_decode #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              result_vld,
    input  logic [`NOU_SID_WIDTH-1:0]         res_sid,
    input  logic [`NOU_RSP_TYPE_ID_WIDTH-1:0] res_type,
    input  logic [`NOU_PKT_ID_WIDTH-1:0]      res_pkt_id,
    input  logic                              res_status,
    input  logic [`NOU_ERR_CODE_WIDTH-1:0]    res_err_code,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [`NOU_SID_WIDTH-1:0]         out_sid,
    output logic [`NOU_PKT_ID_WIDTH-1:0]      out_pkt_id,
    output logic                              out_status,
    output logic [`NOU_ERR_CODE_WIDTH-1:0]    out_err_code,
    output logic [9:0]                        out_err_vec,
    output logic                              out_err_unknown,
    output logic [$clog2(DEPTH):0]            fifo_cnt,
    output logic [CNT_WIDTH-1:0]              ok_cnt,
    output logic [CNT_WIDTH-1:0]              err_cnt,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic                              ovf_flag,
    output logic                              type_err_flag,
    input  logic                              cnt_clr,
    input  logic                              flag_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = `NOU_ERR_CODE_WIDTH;

    logic [`NOU_SID_WIDTH-1:0]    sid_mem  [DEPTH];
    logic [`NOU_PKT_ID_WIDTH-1:0] pkt_mem  [DEPTH];
    logic                         st_mem   [DEPTH];
    logic [EW-1:0]                code_mem [DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] ok_q, ok_d, err_q, err_d, drop_q, drop_d;
    logic                 ovf_q, ovf_d, type_q, type_d;
    logic                 type_ok, full, pop, push, drop;

    assign type_ok = (res_type == `SNT_PKT_RSP_TYPE);
    assign full    = (cnt_q == CW'(DEPTH));
    assign out_vld = (cnt_q != '0);
    assign pop     = out_vld & out_rdy;
    // A full FIFO can still take a record when the head leaves in the same cycle.
    assign push    = result_vld & type_ok & (~full | pop);
    assign drop    = result_vld & type_ok & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end

    always_comb begin
        ok_d   = ok_q;
        err_d  = err_q;
        drop_d = drop_q;
        if (push && res_status == `RSP_STATUS_OK && ok_q != '1)  ok_d  = ok_q + CNT_WIDTH'(1);
        if (push && res_status != `RSP_STATUS_OK && err_q != '1) err_d = err_q + CNT_WIDTH'(1);
        if (drop && drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
        if (cnt_clr) begin
            ok_d   = '0;
            err_d  = '0;
            drop_d = '0;
        end
        // Set has priority over clear so a coincident event is never lost.
        ovf_d  = drop | (ovf_q & ~flag_clr);
        type_d = (result_vld & ~type_ok) | (type_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ok_q     <= '0;
            err_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            type_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            type_q   <= type_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sid_mem[wr_ptr_q]  <= res_sid;
            pkt_mem[wr_ptr_q]  <= res_pkt_id;
            st_mem[wr_ptr_q]   <= res_status;
            code_mem[wr_ptr_q] <= res_err_code;
        end
    end

    // Head fields are gated by out_vld so they read as zero while empty or in reset.
    assign out_sid      = out_vld ? sid_mem[rd_ptr_q]  : '0;
    assign out_pkt_id   = out_vld ? pkt_mem[rd_ptr_q]  : '0;
    assign out_status   = out_vld ? st_mem[rd_ptr_q]   : 1'b0;
    assign out_err_code = out_vld ? code_mem[rd_ptr_q] : '0;

    always_comb begin
        out_err_vec     = '0;
        out_err_unknown = 1'b0;
        if (out_vld && out_status == `RSP_STATUS_ERR) begin
            if (out_err_code >= EW'(1) && out_err_code <= EW'(10))
                out_err_vec = 10'b1 << (out_err_code - EW'(1));
            else
                out_err_unknown = 1'b1;
        end
    end

    assign fifo_cnt      = cnt_q;
    assign ok_cnt        = ok_q;
    assign err_cnt       = err_q;
    assign drop_cnt      = drop_q;
    assign ovf_flag      = ovf_q;
    assign type_err_flag = type_q;
endmodule

// File: tb/tb_spu_result_decode.sv
// tb/tb_spu_result_decode.sv - scoreboard bench for spu_result_decode
`ifndef NOU_SID_WIDTH
`define NOU_SID_WIDTH 4
`endif
`ifndef NOU_RSP_TYPE_ID_WIDTH
`define NOU_RSP_TYPE_ID_WIDTH 2
`endif
`ifndef NOU_PKT_ID_WIDTH
`define NOU_PKT_ID_WIDTH 8
`endif
`ifndef NOU_ERR_CODE_WIDTH
`define NOU_ERR_CODE_WIDTH 4
`endif
`ifndef RSP_STATUS_OK
`define RSP_STATUS_OK 1'b0
`endif
`ifndef RSP_STATUS_ERR
`define RSP_STATUS_ERR 1'b1
`endif
`ifndef SNT_PKT_RSP_TYPE
`define SNT_PKT_RSP_TYPE 2'd1
`endif

module tb_spu_result_decode;
    localparam int DEPTH = 8;
    localparam int CNT_WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       result_vld = 1'b0;
    logic [3:0] res_sid = '0;
    logic [1:0] res_type = '0;
    logic [7:0] res_pkt_id = '0;
    logic       res_status = 1'b0;
    logic [3:0] res_err_code = '0;
    logic       out_vld;
    logic       out_rdy = 1'b0;
    logic [3:0] out_sid;
    logic [7:0] out_pkt_id;
    logic       out_status;
    logic [3:0] out_err_code;
    logic [9:0] out_err_vec;
    logic       out_err_unknown;
    logic [3:0] fifo_cnt;
    logic [3:0] ok_cnt, err_cnt, drop_cnt;
    logic       ovf_flag, type_err_flag;
    logic       cnt_clr = 1'b0;
    logic       flag_clr = 1'b0;

    typedef struct packed {
        logic [3:0] sid;
        logic [7:0] pkt;
        logic       st;
        logic [3:0] code;
        logic [9:0] vec;
        logic       unk;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    spu_result_decode #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .result_vld(result_vld), .res_sid(res_sid),
        .res_type(res_type), .res_pkt_id(res_pkt_id), .res_status(res_status),
        .res_err_code(res_err_code), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_sid(out_sid), .out_pkt_id(out_pkt_id), .out_status(out_status),
        .out_err_code(out_err_code), .out_err_vec(out_err_vec),
        .out_err_unknown(out_err_unknown), .fifo_cnt(fifo_cnt), .ok_cnt(ok_cnt),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt), .ovf_flag(ovf_flag),
        .type_err_flag(type_err_flag), .cnt_clr(cnt_clr), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] sid, input logic [7:0] pkt, input logic st,
                         input logic [3:0] code, input logic [1:0] typ, input logic rdy);
        @(posedge clk); #1;
        result_vld   = 1'b1;
        res_sid      = sid;
        res_pkt_id   = pkt;
        res_status   = st;
        res_err_code = code;
        res_type     = typ;
        out_rdy      = rdy;
        cnt_clr      = 1'b0;
        flag_clr     = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        @(posedge clk); #1;
        result_vld = 1'b0;
        out_rdy    = rdy;
        cnt_clr    = 1'b0;
        flag_clr   = 1'b0;
    endtask

    task automatic expect_rec(input logic [3:0] sid, input logic [7:0] pkt, input logic st,
                              input logic [3:0] code, input logic [9:0] vec, input logic unk);
        rec_t r;
        r.sid = sid; r.pkt = pkt; r.st = st; r.code = code; r.vec = vec; r.unk = unk;
        exp_q.push_back(r);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_vld) && n < budget) begin
            idle(1'b1);
            n++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && !out_vld), 32'd1);
    endtask

    // Monitor: compares the head against the scoreboard every cycle it is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_vld", 32'(out_vld), 32'd0);
                end else begin
                    chk("head_sid",  32'(out_sid),         32'(exp_q[0].sid));
                    chk("head_pkt",  32'(out_pkt_id),      32'(exp_q[0].pkt));
                    chk("head_st",   32'(out_status),      32'(exp_q[0].st));
                    chk("head_code", 32'(out_err_code),    32'(exp_q[0].code));
                    chk("err_vec",   32'(out_err_vec),     32'(exp_q[0].vec));
                    chk("err_unk",   32'(out_err_unknown), 32'(exp_q[0].unk));
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_err_vec", 32'(out_err_vec),     32'd0);
                chk("idle_err_unk", 32'(out_err_unknown), 32'd0);
            end
        end
    end

    initial begin
        logic [9:0] vecs [5];
        logic       unks [5];
        logic [3:0] codes [5];
        codes = '{4'd1, 4'd6, 4'd10, 4'd0, 4'd11};
        vecs  = '{10'h001, 10'h020, 10'h200, 10'h000, 10'h000};
        unks  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_ok", 32'(ok_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_flags", 32'({ovf_flag, type_err_flag}), 32'd0);
        chk("rst_fields", 32'({out_sid, out_pkt_id, out_status, out_err_code}), 32'd0);
        rst_n = 1'b1;

        // Three OK records; first held to check fall-through latency.
        drive(4'd1, 8'h11, `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b0);
        expect_rec(4'd1, 8'h11, 1'b0, 4'd0, 10'h0, 1'b0);
        idle(1'b0);
        chk("latency_vld", 32'(out_vld), 32'd1);
        chk("latency_sid", 32'(out_sid), 32'd1);
        drive(4'd2, 8'h22, `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b1);
        expect_rec(4'd2, 8'h22, 1'b0, 4'd0, 10'h0, 1'b0);
        drive(4'd3, 8'h33, `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b1);
        expect_rec(4'd3, 8'h33, 1'b0, 4'd0, 10'h0, 1'b0);
        drain(10);
        chk("t1_ok_cnt", 32'(ok_cnt), 32'd3);
        chk("t1_fifo_cnt", 32'(fifo_cnt), 32'd0);

        // Error decode vectors.
        for (int i = 0; i < 5; i++) begin
            drive(4'(i + 4), 8'(8'h50 + i), `RSP_STATUS_ERR, codes[i], `SNT_PKT_RSP_TYPE, 1'b1);
            expect_rec(4'(i + 4), 8'(8'h50 + i), 1'b1, codes[i], vecs[i], unks[i]);
        end
        drain(10);
        chk("t2_err_cnt", 32'(err_cnt), 32'd5);
        chk("t2_ok_cnt", 32'(ok_cnt), 32'd3);

        // Overflow: DEPTH+2 pushes with no consumer.
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(4'(i), 8'(8'h40 + i), `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b0);
            if (i < DEPTH) expect_rec(4'(i), 8'(8'h40 + i), 1'b0, 4'd0, 10'h0, 1'b0);
        end
        idle(1'b0);
        chk("t3_fifo_cnt", 32'(fifo_cnt), 32'(DEPTH));
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t3_ovf_flag", 32'(ovf_flag), 32'd1);
        chk("t3_head_sid", 32'(out_sid), 32'd0);
        chk("t3_ok_cnt", 32'(ok_cnt), 32'd11);

        // Full FIFO with a simultaneous pop still accepts.
        drive(4'hA, 8'h80, `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b1);
        expect_rec(4'hA, 8'h80, 1'b0, 4'd0, 10'h0, 1'b0);
        idle(1'b0);
        chk("t4_fifo_cnt", 32'(fifo_cnt), 32'(DEPTH));
        chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("t4_ok_cnt", 32'(ok_cnt), 32'd12);
        drain(20);
        chk("t4_fifo_empty", 32'(fifo_cnt), 32'd0);

        // Bad response type is flagged and discarded.
        drive(4'h5, 8'h90, `RSP_STATUS_OK, 4'd0, 2'd2, 1'b1);
        idle(1'b1);
        chk("t5_type_flag", 32'(type_err_flag), 32'd1);
        chk("t5_fifo_cnt", 32'(fifo_cnt), 32'd0);
        chk("t5_counts", 32'({ok_cnt, err_cnt, drop_cnt}), 32'({4'd12, 4'd5, 4'd2}));
        drive(4'h5, 8'h91, `RSP_STATUS_OK, 4'd0, 2'd3, 1'b1);
        flag_clr = 1'b1;
        idle(1'b1);
        chk("t5_set_wins", 32'(type_err_flag), 32'd1);
        chk("t5_ovf_cleared", 32'(ovf_flag), 32'd0);
        flag_clr = 1'b1;
        idle(1'b1);
        chk("t5_flags_clr", 32'({ovf_flag, type_err_flag}), 32'd0);

        // Saturation of ok_cnt, then clear beats a coincident increment.
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 8'(i), `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b1);
            expect_rec(4'(i), 8'(i), 1'b0, 4'd0, 10'h0, 1'b0);
        end
        drain(10);
        chk("t6_ok_sat", 32'(ok_cnt), 32'd15);
        drive(4'hC, 8'hCC, `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b1);
        expect_rec(4'hC, 8'hCC, 1'b0, 4'd0, 10'h0, 1'b0);
        cnt_clr = 1'b1;
        idle(1'b1);
        chk("t6_clr_ok", 32'(ok_cnt), 32'd0);
        chk("t6_clr_err_drop", 32'({err_cnt, drop_cnt}), 32'd0);
        drain(10);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) begin
            drive(4'(i + 1), 8'(8'hE0 + i), `RSP_STATUS_OK, 4'd0, `SNT_PKT_RSP_TYPE, 1'b0);
            expect_rec(4'(i + 1), 8'(8'hE0 + i), 1'b0, 4'd0, 10'h0, 1'b0);
        end
        idle(1'b0);
        chk("t7_fifo_cnt", 32'(fifo_cnt), 32'd3);
        idle(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_vld_drop", 32'(out_vld), 32'd0);
        chk("t7_fifo_zero", 32'(fifo_cnt), 32'd0);
        exp_q.delete();
        out_rdy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1'b0);
        chk("t7_after_rst", 32'({out_vld, ok_cnt}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spu_result_decode.md
Name: spu_result_decode

Overview:
- Receiving end of the SPU packet-result record produced by the NOU result encoder.
- Captures every result record (no backpressure exists upstream) into a FIFO, decodes status and error code into a one-hot error vector, and presents records to the NOU control/CSR side over a valid/ready pop interface.
- Keeps saturating OK/ERR/drop statistics and sticky overflow and bad-type flags.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- result_vld  in  1  one record per asserted cycle; no ready, always sampled
- res_sid  in  `NOU_SID_WIDTH  stream id
- res_type  in  `NOU_RSP_TYPE_ID_WIDTH  response type
- res_pkt_id  in  `NOU_PKT_ID_WIDTH  packet id
- res_status  in  1  `RSP_STATUS_OK or `RSP_STATUS_ERR
- res_err_code  in  `NOU_ERR_CODE_WIDTH  error code, 0 when OK
- out_vld  out  1  head record available
- out_rdy  in  1  consumer pops the head when out_vld & out_rdy
- out_sid  out  `NOU_SID_WIDTH  head sid
- out_pkt_id  out  `NOU_PKT_ID_WIDTH  head pkt_id
- out_status  out  1  head status
- out_err_code  out  `NOU_ERR_CODE_WIDTH  head raw error code
- out_err_vec  out  10  one-hot decoded error; bit i = code i+1
- out_err_unknown  out  1  status ERR with code outside 1..10
- fifo_cnt  out  $clog2(DEPTH)+1  occupancy
- ok_cnt, err_cnt, drop_cnt  out  CNT_WIDTH  statistics
- ovf_flag  out  1  sticky: record dropped on full FIFO
- type_err_flag  out  1  sticky: record with res_type != `SNT_PKT_RSP_TYPE
- cnt_clr  in  1  pulse; zeroes all three counters
- flag_clr  in  1  pulse; clears both sticky flags

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty. out_vld=0, fifo_cnt=0. All counters 0. Both flags 0. out_* data fields 0.
- Type check: result_vld with res_type != `SNT_PKT_RSP_TYPE sets type_err_flag and is discarded. It is not counted in ok/err/drop and does not enter the FIFO.
- Accept rule: a valid-typed record is written when fifo_cnt < DEPTH, or when fifo_cnt == DEPTH and a pop occurs in the same cycle.
  - Otherwise the record is dropped: drop_cnt +1 and ovf_flag set.
- Latency: a record written at edge N into an empty FIFO gives out_vld=1 after edge N. Output is first-word-fall-through, so the head is visible combinationally from storage with no extra cycle.
- Head fields stay stable while out_vld & !out_rdy. out_rdy with out_vld=0 has no effect.
- fifo_cnt changes as follows: +1 on push only, -1 on pop only, unchanged on push and pop together. Pointers wrap modulo DEPTH.
- Decode is combinational on the head entry. Code mapping:
  - 1 miss_pkt_req
  - 2 miss_routing_req
  - 3 trans_id_mismatch
  - 4 tile_id_mismatch
  - 5 read_sram_error
  - 6 read_sram_timeout
  - 7 snd_head_flt_timeout
  - 8 snd_data_flt_timeout
  - 9 head_flt_rsp_to
  - 10 data_flt_rsp_to
- Decode qualifiers:
  - out_status == `RSP_STATUS_OK forces out_err_vec=0 and out_err_unknown=0.
  - Status ERR with code 0 or >10 (including OR-merged multi-error codes) gives out_err_vec=0 and out_err_unknown=1.
  - When out_vld=0, out_err_vec=0 and out_err_unknown=0.
- Statistics:
  - An accepted record increments ok_cnt if its status is OK, else err_cnt.
  - All counters saturate at all-ones.
  - cnt_clr in the same cycle as an increment: clear wins and the counter becomes 0.
  - flag_clr in the same cycle as a set condition: set wins.

Test Plan:
- Reset, then 3 records (sid 1/2/3, OK, code 0) with out_rdy=1 -> each appears 1 cycle later in order; out_err_vec=0; ok_cnt=3; fifo_cnt returns to 0.
- Records with status ERR and codes 1, 6, 10, 0, 11 -> out_err_vec = 0x001, 0x020, 0x200, 0x000, 0x000; out_err_unknown = 0, 0, 0, 1, 1; err_cnt=5.
- out_rdy=0, push DEPTH+2 records -> fifo_cnt=DEPTH, drop_cnt=2, ovf_flag=1; head is still record 0; drain yields records 0..DEPTH-1 in order.
- FIFO full, push with out_rdy=1 in the same cycle -> record accepted, drop_cnt unchanged, fifo_cnt stays DEPTH.
- Record with res_type != `SNT_PKT_RSP_TYPE -> type_err_flag=1; FIFO and all counters unchanged. flag_clr with no new event clears both flags.
- Force ok_cnt to all-ones via 2^CNT_WIDTH pushes (CNT_WIDTH=4 build) -> it holds at 15. cnt_clr in the same cycle as a push -> 0. Asserting rst_n low mid-drain -> out_vld drops immediately.
